// File: rtl/slp_seq_pkg.sv
// Shared types and constants for the single-layer perceptron training sequencer.
package slp_seq_pkg;

  localparam int EPOCH_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAIN,
    ST_EVAL,
    ST_DONE
  } slp_state_e;

endpackage

// File: rtl/slp_train_seq_if.sv
// Sample write handshake between a sample producer and the training sequencer.
interface slp_train_seq_if #(
  parameter int IN     = 8,
  parameter int I_PREC = 16,
  parameter int O_PREC = 16
);
  logic                         s_valid;
  logic                         s_ready;
  logic [IN-1:0][I_PREC-1:0]    s_in;
  logic [O_PREC-1:0]            s_train;

  modport master (output s_valid, s_in, s_train, input s_ready);
  modport slave  (input s_valid, s_in, s_train, output s_ready);
endinterface

// File: rtl/slp_sample_buf.sv
// Register buffer of training samples: one write port, one combinational read port.
module slp_sample_buf #(
  parameter int IN     = 8,
  parameter int I_PREC = 16,
  parameter int O_PREC = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [IN-1:0][I_PREC-1:0] wr_in,
  input  logic [O_PREC-1:0]         wr_train,
  input  logic [AW-1:0]             rd_addr,
  output logic [IN-1:0][I_PREC-1:0] rd_in,
  output logic [O_PREC-1:0]         rd_train
);

  // No reset: entries beyond the fill count are never read.
  logic [IN-1:0][I_PREC-1:0] mem_in    [DEPTH];
  logic [O_PREC-1:0]         mem_train [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_in[wr_addr]    <= wr_in;
      mem_train[wr_addr] <= wr_train;
    end
  end

  assign rd_in    = mem_in[rd_addr];
  assign rd_train = mem_train[rd_addr];

endmodule

// File: rtl/slp_train_seq.sv
// Perceptron training sequencer: buffers samples, replays them one per cycle per
// epoch, counts misclassifications and decays the learning rate.
//
//   state    | meaning
//   ST_IDLE  | accepting samples, waiting for start
//   ST_TRAIN | presenting buffer[idx] to the perceptron, p_t_en high
//   ST_EVAL  | one cycle to judge the finished epoch
//   ST_DONE  | results held until start or clear
module slp_train_seq
  import slp_seq_pkg::*;
#(
  parameter int IN        = 8,
  parameter int I_PREC    = 16,
  parameter int O_PREC    = 16,
  parameter int R_PREC    = 16,
  parameter int DEPTH     = 16,
  parameter int MAX_EPOCH = 64,
  parameter int DECAY     = 8
) (
  input  logic                          clk,
  input  logic                          reset_,
  slp_train_seq_if.slave                s,
  input  logic                          start,
  input  logic                          clear,
  input  logic [R_PREC-1:0]             rate_init,
  output logic [IN-1:0][I_PREC-1:0]     p_in,
  output logic [O_PREC-1:0]             p_train,
  output logic [R_PREC-1:0]             p_rate,
  output logic                          p_t_en,
  input  logic [O_PREC-1:0]             p_out,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [EPOCH_W-1:0]            epoch,
  output logic [$clog2(DEPTH+1)-1:0]    err_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(MAX_EPOCH - 1);
  localparam logic [EPOCH_W-1:0] DECAY_LOAD = (DECAY > 0) ? EPOCH_W'(DECAY - 1) : '0;

  slp_state_e                state;
  logic [CW-1:0]             count;
  logic [AW-1:0]             idx;
  logic [EPOCH_W-1:0]        decay_cnt;
  logic [IN-1:0][I_PREC-1:0] rd_in;
  logic [O_PREC-1:0]         rd_train;
  logic                      wr_fire;
  logic                      last_sample;
  logic                      miss;
  logic                      launch;

  assign s.s_ready   = (state == ST_IDLE) && (count < CW'(DEPTH)) && !start && !clear;
  assign wr_fire     = s.s_valid && s.s_ready;
  assign last_sample = (CW'(idx) == count - CW'(1));
  assign launch      = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign p_in    = p_t_en ? rd_in : '0;
  assign p_train = p_t_en ? rd_train : '0;
  assign miss    = (p_out != p_train);

  slp_sample_buf #(
    .IN     (IN),
    .I_PREC (I_PREC),
    .O_PREC (O_PREC),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk      (clk),
    .wr_en    (wr_fire),
    .wr_addr  (count[AW-1:0]),
    .wr_in    (s.s_in),
    .wr_train (s.s_train),
    .rd_addr  (idx),
    .rd_in    (rd_in),
    .rd_train (rd_train)
  );

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= ST_IDLE;
      count     <= '0;
      idx       <= '0;
      epoch     <= '0;
      err_cnt   <= '0;
      p_rate    <= '0;
      decay_cnt <= '0;
      p_t_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      count     <= '0;
      idx       <= '0;
      p_t_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
    end else if (launch) begin
      idx       <= '0;
      epoch     <= '0;
      err_cnt   <= '0;
      converged <= 1'b0;
      if (count != '0) begin
        state     <= ST_TRAIN;
        p_rate    <= rate_init;
        decay_cnt <= DECAY_LOAD;
        p_t_en    <= 1'b1;
        busy      <= 1'b1;
        done      <= 1'b0;
      end else begin
        state <= ST_DONE;
        done  <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_fire) count <= count + CW'(1);
        end
        ST_TRAIN: begin
          if (miss) err_cnt <= err_cnt + CW'(1);
          if (last_sample) begin
            state  <= ST_EVAL;
            idx    <= '0;
            p_t_en <= 1'b0;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        ST_EVAL: begin
          if (err_cnt == '0 || epoch == LAST_EPOCH) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= (err_cnt == '0);
          end else begin
            state   <= ST_TRAIN;
            epoch   <= epoch + EPOCH_W'(1);
            idx     <= '0;
            err_cnt <= '0;
            p_t_en  <= 1'b1;
            // Halve every DECAY epochs; a rate of 1 stays 1, and 0 stays 0.
            if (DECAY > 0) begin
              if (decay_cnt == '0) begin
                decay_cnt <= DECAY_LOAD;
                if (p_rate > R_PREC'(1)) p_rate <= p_rate >> 1;
              end else begin
                decay_cnt <= decay_cnt - EPOCH_W'(1);
              end
            end
          end
        end
        ST_DONE: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/slp_train_seq.md
SLP_TRAIN_SEQ -- requirements
Module: slp_train_seq

Interface
REQ-001 The module SHALL have parameter IN, default 8, the number of perceptron inputs per sample.
REQ-002 The module SHALL have parameter I_PREC, default 16, the width of each input element.
REQ-003 The module SHALL have parameter O_PREC, default 16, the width of the training label and of the inference result.
REQ-004 The module SHALL have parameter R_PREC, default 16, the learning-rate width.
REQ-005 The module SHALL have parameter DEPTH, default 16, the sample buffer capacity.
REQ-006 The module SHALL have parameter MAX_EPOCH, default 64, the epoch limit.
REQ-007 The module SHALL have parameter DECAY, default 8, the number of epochs per rate halving; 0 disables halving.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 reset_  in  1  synchronous, active-low reset.
REQ-010 s_valid  in  1 / s_ready  out  1  sample write handshake; a write occurs when both are 1.
REQ-011 s_in  in  IN*I_PREC (packed [IN][I_PREC])  sample inputs; s_train  in  O_PREC  sample label.
REQ-012 start  in  1  begin training; clear  in  1  abort and empty the buffer; rate_init  in  R_PREC  initial learning rate.
REQ-013 p_in  out  IN*I_PREC / p_train  out  O_PREC / p_rate  out  R_PREC / p_t_en  out  1  drive the perceptron training port.
REQ-014 p_out  in  O_PREC  the perceptron's combinational inference result for p_in.
REQ-015 busy  out  1, done  out  1, converged  out  1, epoch  out  16, err_cnt  out  clog2(DEPTH+1)  status outputs.

Function
REQ-016 The FSM SHALL have the states IDLE, TRAIN, EVAL and DONE.
REQ-017 In IDLE, s_ready SHALL be (count<DEPTH) & !start & !clear; each handshake SHALL write buffer[count] and increment count.
REQ-018 In IDLE, start with count>0 SHALL latch rate_init into p_rate, zero idx, epoch and err_cnt, and move to TRAIN.
REQ-019 In IDLE, start with count==0 SHALL move to DONE with converged=0 and epoch=0, and p_t_en SHALL never assert.
REQ-020 In TRAIN, every cycle SHALL drive p_in/p_train=buffer[idx] and p_t_en=1, so throughput is one sample per cycle.
REQ-021 In TRAIN, err_cnt SHALL increment in a cycle where p_out!=p_train, with the comparison made in that same cycle.
REQ-022 In TRAIN, idx SHALL increment each cycle, and at idx==count-1 the FSM SHALL move to EVAL.
REQ-023 EVAL SHALL last 1 cycle with p_t_en=0.
REQ-024 In EVAL, err_cnt==0 SHALL move to DONE with converged=1.
REQ-025 In EVAL, otherwise epoch==MAX_EPOCH-1 SHALL move to DONE with converged=0.
REQ-026 In EVAL, otherwise the block SHALL increment epoch, zero idx and err_cnt, and return to TRAIN.
REQ-027 On an EVAL→TRAIN transition where DECAY>0 and (epoch+1)%DECAY==0, p_rate SHALL shift right by 1, floored at 1 if nonzero.
REQ-028 In DONE, done=1 and epoch, err_cnt and converged SHALL hold.
REQ-029 In DONE, start SHALL retrain from epoch 0 on the same buffer.
REQ-030 In DONE, clear SHALL go to IDLE with count=0.
REQ-031 clear in any state SHALL go to IDLE with count=0, done=0 and converged=0; clear SHALL have priority over start.
REQ-032 busy SHALL be 1 in TRAIN and EVAL only.
REQ-033 s_ready SHALL be 0 outside IDLE.
REQ-034 p_in, p_train and p_t_en SHALL be 0 outside TRAIN.

Reset
REQ-035 When reset_=0 at a clock edge, the state SHALL become IDLE, count/idx/epoch/err_cnt SHALL become 0, and every output SHALL become 0, from any state including mid-TRAIN.
REQ-036 Buffer contents SHALL NOT need reset, but they SHALL be unreachable until rewritten.

Structure
REQ-037 Package slp_seq_pkg SHALL hold the state enum type and the epoch-width constant (16).
REQ-038 Sub-module slp_sample_buf SHALL implement the DEPTH-entry register buffer with one write port and one combinational read port indexed by idx.

Verification (IN=2, DEPTH=4, MAX_EPOCH=3, DECAY=1)
REQ-039 Write 5 samples with s_valid=1 -> 4 accepted, s_ready=0 on the 5th, count=4.
REQ-040 With p_out looped to p_train, start -> p_t_en=1 for 4 cycles, EVAL, then done=1, converged=1, epoch=0.
REQ-041 With p_out=~p_train, start -> done after 15 cycles, converged=0, epoch=2, err_cnt=4, p_t_en high 12 cycles.
REQ-042 rate_init=8 with p_out=~p_train -> p_rate is 8, 4, 2 in epochs 0, 1, 2; rate_init=1 stays 1.
REQ-043 Start with count=0 -> next cycle done=1, converged=0, p_t_en never 1.
REQ-044 reset_=0 in the 3rd TRAIN cycle -> next cycle IDLE, all outputs 0, s_ready=1.
